// File: rtl/isdu_param.sv
// isdu_param: LC-3 style instruction sequencer with MEM_WAIT-cycle SRAM accesses.
// Optional build macro ISDU_PAUSE_IR_EN adds a Continue handshake between IR load and decode.
module isdu_param #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic [6:0] LD,
    output logic [3:0] Gate,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Busy
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned LD_MAR = 6;
    localparam int unsigned LD_MDR = 5;
    localparam int unsigned LD_IR  = 4;
    localparam int unsigned LD_BEN = 3;
    localparam int unsigned LD_CC  = 2;
    localparam int unsigned LD_REG = 1;
    localparam int unsigned LD_PC  = 0;
    localparam int unsigned G_PC   = 3;
    localparam int unsigned G_MDR  = 2;
    localparam int unsigned G_ALU  = 1;
    localparam int unsigned G_MARM = 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_HALTED, S_18, S_33, S_35, S_32,
        S_01, S_05, S_09, S_00, S_22, S_12,
        S_04, S_21, S_20, S_06, S_25, S_27,
        S_07, S_23, S_16, S_PSE1, S_PSE2
`ifdef ISDU_PAUSE_IR_EN
        , S_PIR1, S_PIR2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_last;

    assign mem_last = (cnt_q == CNT_LAST);
    assign Mem_CE   = 1'b0;
    assign Mem_UB   = 1'b0;
    assign Mem_LB   = 1'b0;
    assign Busy     = (state_q != S_HALTED);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Moore control word; the wait counter clears whenever a memory state is left
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        LD       = '0;
        Gate     = '0;
        PCMUX    = 2'b00;
        DRMUX    = 2'b00;
        SR1MUX   = 2'b00;
        ADDR2MUX = 2'b00;
        ALUK     = 2'b00;
        SR2MUX   = 1'b0;
        ADDR1MUX = 1'b0;
        Mem_OE   = 1'b1;
        Mem_WE   = 1'b1;
        case (state_q)
            S_HALTED: if (Run) state_d = S_18;
            S_18: begin
                Gate[G_PC] = 1'b1;
                LD[LD_MAR] = 1'b1;
                LD[LD_PC]  = 1'b1;
                state_d    = S_33;
            end
            S_33, S_25: begin
                Mem_OE = 1'b0;
                if (mem_last) begin
                    LD[LD_MDR] = 1'b1;
                    state_d    = (state_q == S_33) ? S_35 : S_27;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_35: begin
                Gate[G_MDR] = 1'b1;
                LD[LD_IR]   = 1'b1;
`ifdef ISDU_PAUSE_IR_EN
                state_d     = S_PIR1;
`else
                state_d     = S_32;
`endif
            end
`ifdef ISDU_PAUSE_IR_EN
            S_PIR1: if (Continue) state_d = S_PIR2;
            S_PIR2: if (!Continue) state_d = S_32;
`endif
            S_32: begin
                LD[LD_BEN] = 1'b1;
                case (Opcode)
                    4'b0001: state_d = S_01;
                    4'b0101: state_d = S_05;
                    4'b1001: state_d = S_09;
                    4'b0000: state_d = S_00;
                    4'b1100: state_d = S_12;
                    4'b0100: state_d = S_04;
                    4'b0110: state_d = S_06;
                    4'b0111: state_d = S_07;
                    4'b1101: state_d = S_PSE1;
                    default: state_d = S_18;
                endcase
            end
            S_01, S_05, S_09: begin
                ALUK       = (state_q == S_01) ? 2'b00 : (state_q == S_05) ? 2'b01 : 2'b10;
                SR2MUX     = (state_q != S_09) && IR_5;
                SR1MUX     = 2'b01;
                Gate[G_ALU] = 1'b1;
                LD[LD_REG] = 1'b1;
                LD[LD_CC]  = 1'b1;
                state_d    = S_18;
            end
            S_00: state_d = BEN ? S_22 : S_18;
            S_22, S_21: begin
                ADDR2MUX  = (state_q == S_22) ? 2'b10 : 2'b11;
                PCMUX     = 2'b10;
                LD[LD_PC] = 1'b1;
                state_d   = S_18;
            end
            S_12, S_20: begin
                SR1MUX    = 2'b01;
                ADDR1MUX  = 1'b1;
                PCMUX     = 2'b10;
                LD[LD_PC] = 1'b1;
                state_d   = S_18;
            end
            S_04: begin
                Gate[G_PC] = 1'b1;
                DRMUX      = 2'b01;
                LD[LD_REG] = 1'b1;
                state_d    = IR_11 ? S_21 : S_20;
            end
            S_06, S_07: begin
                SR1MUX       = 2'b01;
                ADDR1MUX     = 1'b1;
                ADDR2MUX     = 2'b01;
                Gate[G_MARM] = 1'b1;
                LD[LD_MAR]   = 1'b1;
                state_d      = (state_q == S_06) ? S_25 : S_23;
            end
            S_27: begin
                Gate[G_MDR] = 1'b1;
                LD[LD_REG]  = 1'b1;
                LD[LD_CC]   = 1'b1;
                state_d     = S_18;
            end
            S_23: begin
                ALUK        = 2'b11;
                Gate[G_ALU] = 1'b1;
                LD[LD_MDR]  = 1'b1;
                state_d     = S_16;
            end
            S_16: begin
                Mem_WE = 1'b0;
                if (mem_last) state_d = S_18;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            S_PSE1: if (Continue) state_d = S_PSE2;
            S_PSE2: if (!Continue) state_d = S_18;
            default: state_d = S_HALTED;
        endcase
    end

endmodule
